// File: rtl/convolution_pkg.sv
// Shared types and default widths for the convolution accumulate/write path.
package convolution_pkg;

    localparam int unsigned DATA_WIDTH_DEF      = 8;
    localparam int unsigned DATA_WIDTH_ADDR_DEF = 5;
    localparam int unsigned ACC_WIDTH           = 2 * DATA_WIDTH_DEF + DATA_WIDTH_ADDR_DEF;
    localparam int unsigned ZADDR_WIDTH         = DATA_WIDTH_ADDR_DEF + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } strobe_flags_t;

endpackage

// File: rtl/convolution_strobe_delay.sv
// Delays the term strobes and output index so they line up with the memory read data.
module convolution_strobe_delay
    import convolution_pkg::*;
#(
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned K_WIDTH  = ZADDR_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               valid,
    input  logic               first,
    input  logic               last,
    input  logic [K_WIDTH-1:0] k,
    output logic               valid_d,
    output logic               first_d,
    output logic               last_d,
    output logic [K_WIDTH-1:0] k_d
);

    strobe_flags_t      flags_q [READ_LAT];
    logic [K_WIDTH-1:0] k_q     [READ_LAT];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < int'(READ_LAT); i++) begin
                flags_q[i] <= '0;
                k_q[i]     <= '0;
            end
        end else begin
            flags_q[0] <= '{valid: valid, first: first, last: last};
            k_q[0]     <= k;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                flags_q[i] <= flags_q[i-1];
                k_q[i]     <= k_q[i-1];
            end
        end
    end

    assign valid_d = flags_q[READ_LAT-1].valid;
    assign first_d = flags_q[READ_LAT-1].first;
    assign last_d  = flags_q[READ_LAT-1].last;
    assign k_d     = k_q[READ_LAT-1];

endmodule

// File: rtl/convolution_accum_write.sv
// Multiplies aligned X/Y read data, accumulates per output index k and issues one Z write per k.
module convolution_accum_write
    import convolution_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH_ADDR = DATA_WIDTH_ADDR_DEF,
    parameter int unsigned READ_LAT        = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start_i,
    input  logic [DATA_WIDTH_ADDR:0]                numZ_i,
    input  logic                                    term_valid_i,
    input  logic                                    term_first_i,
    input  logic                                    term_last_i,
    input  logic [DATA_WIDTH_ADDR:0]                k_i,
    input  logic [DATA_WIDTH-1:0]                   dataX_i,
    input  logic [DATA_WIDTH-1:0]                   dataY_i,
    output logic [2*DATA_WIDTH+DATA_WIDTH_ADDR-1:0] dataZ_o,
    output logic [DATA_WIDTH_ADDR:0]                addrZ_o,
    output logic                                    writeZ_o,
    output logic                                    busy_o,
    output logic                                    done_o
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned ACC_W  = 2 * DATA_WIDTH + DATA_WIDTH_ADDR;
    localparam int unsigned ZA_W   = DATA_WIDTH_ADDR + 1;

    state_t            state;
    logic [ZA_W-1:0]   numz_q;
    logic [ZA_W-1:0]   wcnt;

    logic              d_valid;
    logic              d_first;
    logic              d_last;
    logic [ZA_W-1:0]   d_k;

    logic [PROD_W-1:0] prod;
    logic              s_valid;
    logic              s_first;
    logic              s_last;
    logic [ZA_W-1:0]   s_k;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next_c;
    logic              clr_c;

    // Nothing flows through the pipeline outside a run.
    assign clr_c = (state == IDLE);

    convolution_strobe_delay #(
        .READ_LAT (READ_LAT),
        .K_WIDTH  (ZA_W)
    ) u_strobe_delay (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_c),
        .valid   (term_valid_i),
        .first   (term_first_i),
        .last    (term_last_i),
        .k       (k_i),
        .valid_d (d_valid),
        .first_d (d_first),
        .last_d  (d_last),
        .k_d     (d_k)
    );

    // The write value is taken from the same sum that updates acc, so a following first term cannot disturb it.
    assign acc_next_c = s_first ? ACC_W'(prod) : acc + ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (rst || clr_c) begin
            prod     <= '0;
            s_valid  <= 1'b0;
            s_first  <= 1'b0;
            s_last   <= 1'b0;
            s_k      <= '0;
            acc      <= '0;
            wcnt     <= '0;
            writeZ_o <= 1'b0;
            dataZ_o  <= '0;
            addrZ_o  <= '0;
        end else begin
            writeZ_o <= 1'b0;
            if (d_valid) begin
                prod <= PROD_W'(dataX_i) * PROD_W'(dataY_i);
            end
            s_valid <= d_valid;
            s_first <= d_first;
            s_last  <= d_last;
            s_k     <= d_k;
            if (s_valid) begin
                acc <= acc_next_c;
                if (s_last) begin
                    writeZ_o <= 1'b1;
                    dataZ_o  <= acc_next_c;
                    addrZ_o  <= s_k;
                    wcnt     <= wcnt + ZA_W'(1);
                end
            end
        end
    end

    // Run control: done_o lands the cycle after the final write because wcnt updates with writeZ_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            numz_q <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state  <= RUN;
                        numz_q <= numZ_i;
                        busy_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (wcnt == numz_q) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_convolution_accum_write.sv
// Self-checking bench: directed 2x2 vector table, corner-case sequences and random convolutions.
module tb_convolution_accum_write;
    import convolution_pkg::*;

    localparam int unsigned DW = DATA_WIDTH_DEF;
    localparam int unsigned RL = 2;
    localparam int unsigned ZW = ZADDR_WIDTH;
    localparam int unsigned AW = ACC_WIDTH;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic [ZW-1:0] numZ_i;
    logic          term_valid_i;
    logic          term_first_i;
    logic          term_last_i;
    logic [ZW-1:0] k_i;
    logic [DW-1:0] dataX_i;
    logic [DW-1:0] dataY_i;
    logic [AW-1:0] dataZ_o;
    logic [ZW-1:0] addrZ_o;
    logic          writeZ_o;
    logic          busy_o;
    logic          done_o;

    convolution_accum_write #(
        .DATA_WIDTH      (DW),
        .DATA_WIDTH_ADDR (DATA_WIDTH_ADDR_DEF),
        .READ_LAT        (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .numZ_i       (numZ_i),
        .term_valid_i (term_valid_i),
        .term_first_i (term_first_i),
        .term_last_i  (term_last_i),
        .k_i          (k_i),
        .dataX_i      (dataX_i),
        .dataY_i      (dataY_i),
        .dataZ_o      (dataZ_o),
        .addrZ_o      (addrZ_o),
        .writeZ_o     (writeZ_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: the addressed sample appears RL cycles after the strobe.
    logic [DW-1:0] cur_x;
    logic [DW-1:0] cur_y;
    logic [DW-1:0] px [RL];
    logic [DW-1:0] py [RL];
    always @(posedge clk) begin
        px[0] <= cur_x;
        py[0] <= cur_y;
        for (int i = 1; i < int'(RL); i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
        end
    end
    assign dataX_i = px[RL-1];
    assign dataY_i = py[RL-1];

    typedef struct {
        int     cyc;
        int     addr;
        longint data;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    always @(negedge clk) begin
        if (writeZ_o) wq.push_back('{cyc, int'(addrZ_o), longint'(dataZ_o)});
        if (done_o) dq.push_back(cyc);
    end

    typedef struct {
        bit v;
        bit f;
        bit l;
        bit st;
        int k;
        int x;
        int y;
    } term_t;

    term_t tq[$];

    typedef struct {
        int     x0, x1, y0, y1;
        longint z0, z1, z2;
    } vec_t;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    task automatic add(input bit v, input bit f, input bit l, input bit st,
                       input int k, input int x, input int y);
        term_t t;
        t.v = v; t.f = f; t.l = l; t.st = st;
        t.k = k; t.x = x; t.y = y;
        tq.push_back(t);
    endtask

    task automatic add_idle();
        add(1'b0, 1'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 63)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    endtask

    task automatic drive(input term_t t);
        term_valid_i = t.v;
        term_first_i = t.f;
        term_last_i  = t.l;
        k_i          = ZW'(t.k);
        cur_x        = DW'(t.x);
        cur_y        = DW'(t.y);
        start_i      = t.st;
        if (t.st) numZ_i = ZW'($urandom);
    endtask

    // Starts a run, plays tq, then checks write timing/addresses and the done pulse.
    task automatic run(input int numz);
        int exp_cyc[$];
        int exp_k[$];
        int s;
        int n;
        int exp_done;
        wq.delete();
        dq.delete();
        @(negedge clk);
        term_valid_i = 1'b0;
        start_i      = 1'b1;
        numZ_i       = ZW'(numz);
        s            = cyc;
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_after_start", longint'(busy_o), 1);
        foreach (tq[i]) begin
            drive(tq[i]);
            if (tq[i].v && tq[i].l) begin
                exp_cyc.push_back(cyc + int'(RL) + 2);
                exp_k.push_back(tq[i].k);
            end
            @(negedge clk);
        end
        term_valid_i = 1'b0;
        start_i      = 1'b0;
        n = 0;
        while (dq.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("done_timeout", longint'(n < 400), 1);
        exp_done = (exp_cyc.size() == 0) ? s + 2 : exp_cyc[$] + 1;
        chk("done_count", dq.size(), 1);
        if (dq.size() > 0) chk("done_cycle", dq[0], exp_done);
        chk("write_count", wq.size(), exp_cyc.size());
        for (int i = 0; i < wq.size() && i < exp_cyc.size(); i++) begin
            chk("write_cycle", wq[i].cyc, exp_cyc[i]);
            chk("write_addr", wq[i].addr, exp_k[i]);
        end
        chk("busy_end", longint'(busy_o), 0);
    endtask

    task automatic chk_data(input longint z[$]);
        for (int i = 0; i < wq.size() && i < z.size(); i++) begin
            chk("write_data", wq[i].data, z[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vt[4];
        longint zq[$];
        int     gs[7];

        vt[0] = '{1, 2, 3, 4, 3, 10, 8};
        vt[1] = '{255, 255, 255, 255, 65025, 130050, 65025};
        vt[2] = '{0, 5, 7, 0, 0, 35, 0};
        vt[3] = '{2, 3, 4, 5, 8, 22, 15};
        gs    = '{1, 2, 3, 4, 3, 2, 1};

        rst = 1'b1; start_i = 1'b0; numZ_i = '0;
        term_valid_i = 1'b0; term_first_i = 1'b0; term_last_i = 1'b0;
        k_i = '0; cur_x = '0; cur_y = '0;
        repeat (3) @(negedge clk);
        chk("reset_dataZ", longint'(dataZ_o), 0);
        chk("reset_addrZ", longint'(addrZ_o), 0);
        chk("reset_writeZ", longint'(writeZ_o), 0);
        chk("reset_busy", longint'(busy_o), 0);
        chk("reset_done", longint'(done_o), 0);
        rst = 1'b0;

        // Terms presented while idle must never produce writes.
        wq.delete();
        dq.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            term_valid_i = 1'b1; term_first_i = 1'b1; term_last_i = 1'b1;
            k_i = ZW'(i); cur_x = 8'd9; cur_y = 8'd9;
        end
        @(negedge clk);
        term_valid_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("idle_noise_writes", wq.size(), 0);
        chk("idle_noise_done", dq.size(), 0);

        // Table: 2x2 convolutions; vector 3 also carries a stray start_i mid-run.
        foreach (vt[v]) begin
            tq.delete();
            add(1'b1, 1'b1, 1'b1, 1'b0, 0, vt[v].x0, vt[v].y0);
            add(1'b1, 1'b1, 1'b0, (v == 3), 1, vt[v].x0, vt[v].y1);
            add(1'b1, 1'b0, 1'b1, 1'b0, 1, vt[v].x1, vt[v].y0);
            add(1'b1, 1'b1, 1'b1, 1'b0, 2, vt[v].x1, vt[v].y1);
            run(3);
            zq.delete();
            zq.push_back(vt[v].z0);
            zq.push_back(vt[v].z1);
            zq.push_back(vt[v].z2);
            chk_data(zq);
        end

        // 32 full-scale terms into one output index.
        tq.delete();
        for (int j = 0; j < 32; j++) add(1'b1, (j == 0), (j == 31), 1'b0, 5, 255, 255);
        run(1);
        zq.delete();
        zq.push_back(64'd2080800);
        chk_data(zq);

        // Back-to-back k changes with unit data: each Z equals its term count.
        tq.delete();
        zq.delete();
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < gs[k]; j++) add(1'b1, (j == 0), (j == gs[k] - 1), 1'b0, k, 1, 1);
            zq.push_back(longint'(gs[k]));
        end
        run(7);
        chk_data(zq);

        // numZ = 0: immediate completion, no writes.
        tq.delete();
        run(0);

        // Reset with terms in flight aborts the run silently.
        wq.delete();
        dq.delete();
        @(negedge clk);
        start_i = 1'b1; numZ_i = ZW'(3);
        @(negedge clk);
        start_i = 1'b0;
        term_valid_i = 1'b1; term_first_i = 1'b1; term_last_i = 1'b1; k_i = '0;
        cur_x = 8'd5; cur_y = 8'd6;
        @(negedge clk);
        term_first_i = 1'b1; term_last_i = 1'b0; k_i = ZW'(1);
        @(negedge clk);
        term_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", longint'(busy_o), 0);
        chk("abort_writeZ", longint'(writeZ_o), 0);
        chk("abort_done", longint'(done_o), 0);
        repeat (10) @(negedge clk);
        chk("abort_writes", wq.size(), 0);
        chk("abort_dones", dq.size(), 0);

        tq.delete();
        add(1'b1, 1'b1, 1'b1, 1'b0, 0, vt[0].x0, vt[0].y0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1, vt[0].x0, vt[0].y1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1, vt[0].x1, vt[0].y0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 2, vt[0].x1, vt[0].y1);
        run(3);
        zq.delete();
        zq.push_back(vt[0].z0);
        zq.push_back(vt[0].z1);
        zq.push_back(vt[0].z2);
        chk_data(zq);

        // Random convolutions against the direct z[i+j] += x[i]*y[j] definition.
        for (int r = 0; r < 20; r++) begin
            int sx;
            int sy;
            int nz;
            int jlo;
            int jhi;
            int xa[8];
            int ya[8];
            sx = int'($urandom_range(1, 8));
            sy = int'($urandom_range(1, 8));
            nz = sx + sy - 1;
            for (int i = 0; i < 8; i++) begin
                xa[i] = int'($urandom_range(0, 255));
                ya[i] = int'($urandom_range(0, 255));
            end
            zq.delete();
            for (int k = 0; k < nz; k++) zq.push_back(0);
            for (int i = 0; i < sx; i++)
                for (int j = 0; j < sy; j++)
                    zq[i+j] = zq[i+j] + longint'(xa[i]) * longint'(ya[j]);
            tq.delete();
            for (int k = 0; k < nz; k++) begin
                jlo = (k - sy + 1 > 0) ? k - sy + 1 : 0;
                jhi = (k < sx - 1) ? k : sx - 1;
                for (int j = jlo; j <= jhi; j++) begin
                    if ($urandom_range(0, 3) == 0) add_idle();
                    add(1'b1, (j == jlo), (j == jhi), 1'b0, k, xa[j], ya[k-j]);
                end
            end
            run(nz);
            chk_data(zq);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/convolution_accum_write.md
Name: convolution_accum_write

Overview:
- Data-return side of the convolution address path: consumes the X/Y memory read data produced for addresses (j, k-j).
- Multiplies each aligned pair and accumulates the products per output index k.
- Issues one Z-memory write per k, with z[k] = sum over j of x[j]*y[k-j].
- Sits between the X/Y read ports and the Z write port; aligns the control strobes to a fixed read latency.

Parameters:
- DATA_WIDTH, 8, width of one X/Y sample (unsigned).
- DATA_WIDTH_ADDR, 5, X/Y address width; Z address is DATA_WIDTH_ADDR+1 bits.
- READ_LAT, 2, cycles from term strobe to valid dataX_i/dataY_i (address register plus registered memory read); legal range 1..4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse that begins a convolution run.
- numZ_i  in  DATA_WIDTH_ADDR+1  number of outputs (sizeX+sizeY-1); sampled on start_i.
- term_valid_i  in  1  a term (j,k) is being addressed this cycle.
- term_first_i  in  1  term is the first j for the current k.
- term_last_i  in  1  term is the last j for the current k.
- k_i  in  DATA_WIDTH_ADDR+1  output index of the term.
- dataX_i  in  DATA_WIDTH  X read data, valid READ_LAT cycles after the strobe.
- dataY_i  in  DATA_WIDTH  Y read data, same alignment.
- dataZ_o  out  2*DATA_WIDTH+DATA_WIDTH_ADDR  accumulated result.
- addrZ_o  out  DATA_WIDTH_ADDR+1  Z write address.
- writeZ_o  out  1  Z write enable, one cycle per k.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse when the run completes.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; strobe pipeline, product, accumulator and write counter cleared.
- Reset asserted mid-run aborts the run with no write and no done_o.
- FSM IDLE:
  - start_i -> RUN; latch numZ_i; clear the write counter.
  - Terms presented in IDLE are ignored, and the pipeline is held clear.
- FSM RUN:
  - busy_o=1.
  - start_i is ignored.
  - When the write counter reaches the latched numZ -> DONE.
- FSM DONE: done_o=1 for exactly one cycle, busy_o=0, then -> IDLE.
- Alignment:
  - {valid, first, last, k} are delayed READ_LAT cycles by a shift register.
  - The delayed strobe is qualified with dataX_i/dataY_i.
- Product: prod register (2*DATA_WIDTH) <= dataX_i*dataY_i on the aligned cycle (cycle t+READ_LAT for a strobe at t).
- Accumulate, at cycle t+READ_LAT+1:
  - acc <= first ? prod : acc+prod.
  - Accumulator width 2*DATA_WIDTH+DATA_WIDTH_ADDR, so no overflow for up to 2^DATA_WIDTH_ADDR terms.
- Write, at cycle t+READ_LAT+2 for a last term at t:
  - writeZ_o=1, dataZ_o=acc, addrZ_o=delayed k.
  - Write counter increments.
  - Latency from last strobe to write = READ_LAT+2.
- A term with first=last=1 writes its single product.
- Back-to-back terms are accepted every cycle, including a new k's first term immediately after the previous last; the accumulator restart must not corrupt the pending write value.
- numZ_i=0: RUN -> DONE on the next cycle with no writes.
- The last write and done_o are never in the same cycle; done_o follows the final writeZ_o by exactly one cycle.
- An unpaired first without a preceding last simply restarts accumulation; no error flag.

Decomposition:
- Package convolution_pkg:
  - FSM state typedef {IDLE, RUN, DONE}.
  - Localparams ACC_WIDTH = 2*DATA_WIDTH+DATA_WIDTH_ADDR and ZADDR_WIDTH = DATA_WIDTH_ADDR+1.
- One natural sub-module: convolution_strobe_delay, a parameterised READ_LAT-deep shift register for {valid, first, last, k} with synchronous clear.

Test Plan:
1. X=[1,2], Y=[3,4], numZ=3, terms (j,k) = (0,0)L, (0,1)F, (1,1)L, (1,2)FL, READ_LAT=2 -> writes Z[0]=3, Z[1]=10, Z[2]=8; each write 4 cycles after its last strobe; done_o 1 cycle after Z[2].
2. Max samples 255x255, 32 terms for one k -> dataZ_o = 32*65025 = 2080800 with no overflow.
3. Back-to-back k transitions every cycle with all-ones data -> each Z[k] equals its term count; no cycle gaps or lost writes.
4. rst asserted while 2 terms are in the pipeline -> no writeZ_o and no done_o; busy_o=0 the cycle after reset; a subsequent run gives correct results.
5. numZ=0 start -> done_o pulse two cycles after start_i, zero writes.
6. Terms and start_i pulses while in RUN/IDLE respectively as noise -> IDLE terms produce no writes; a second start_i mid-run does not reset the counter.
